// File: rtl/axis_frame_arb.sv
// Frame-level round-robin arbiter: N AXI-Stream sources share one FIFO input.
// Grants whole frames, forwards bad_frame, truncates frames longer than MAX_LEN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin (1-cycle arbitration)
// GRANT | granted port forwarded combinationally to the FIFO
// DRAIN | over-long frame truncated; discard source beats until its tlast
module axis_frame_arb #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 1522
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  output logic [N_PORTS-1:0]            s_axis_tready,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  input  logic [N_PORTS-1:0]            s_bad_frame,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_bad_frame,
  output logic [N_PORTS-1:0]            grant,
  output logic                          busy,
  output logic                          trunc_pulse
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [N_PORTS-1:0]  grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                req_found;
  logic [IW-1:0]       req_idx;
  logic [IW-1:0]       cand;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_bad;
  logic                  at_max;

  // Round-robin search starting just after the last granted port
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = IW'((int'(last_q) + k) % N_PORTS);
      if (!req_found && s_axis_tvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Source-side mux driven by the one-hot grant
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_bad   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant_q[p]) begin
        sel_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid[p];
        sel_last  = s_axis_tlast[p];
        sel_bad   = s_bad_frame[p];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_bad_frame   = 1'b0;
    trunc_pulse   = 1'b0;
    at_max        = (cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[req_idx] = 1'b1;
          last_d           = req_idx;
          cnt_d            = '0;
        end
      end

      GRANT: begin
        m_axis_tdata  = sel_data;
        m_axis_tvalid = sel_valid;
        s_axis_tready = grant_q & {N_PORTS{m_axis_tready}};
        m_axis_tlast  = sel_last | at_max;
        m_bad_frame   = (sel_last & sel_bad) | (at_max & ~sel_last);
        if (sel_valid && m_axis_tready) begin
          // A natural tlast wins over truncation, even on the MAX_LEN-th beat
          if (sel_last) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end else if (at_max) begin
            trunc_pulse = 1'b1;
            state_d     = DRAIN;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DRAIN: begin
        s_axis_tready = grant_q;
        if (sel_valid && sel_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axis_frame_arb.sv
// Bench for axis_frame_arb: per-port source queues, per-port expected-beat
// queues filled at stimulus time, and a frame-level arbitration model in the monitor.
module tb_axis_frame_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int ML = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N-1:0]      drv_valid, pause;
  logic [N-1:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast, s_bad_frame;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, m_bad_frame;
  logic [N-1:0]      grant;
  logic              busy, trunc_pulse;
  logic              rand_rdy, rdy_force, rnd_rdy, gaps;

  assign s_axis_tvalid = drv_valid & ~pause;
  assign m_axis_tready = rand_rdy ? rnd_rdy : rdy_force;

  axis_frame_arb #(.N_PORTS(N), .DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_bad_frame(s_bad_frame),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_bad_frame(m_bad_frame), .grant(grant), .busy(busy),
    .trunc_pulse(trunc_pulse)
  );

  typedef struct packed {logic [DW-1:0] data; logic last; logic bad;} src_t;
  typedef struct packed {logic [DW-1:0] data; logic last; logic bad; logic trunc;} exp_t;

  src_t src_q [N][$];
  exp_t exp_q [N][$];
  logic [DW-1:0] fd[$];
  int glog[$];
  int total = 0;
  int bad_cnt = 0;
  int m_state, m_owner, m_ptr;
  int trunc_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected output = first ML beats; forced tlast/bad on beat ML of longer frames
  task automatic push_frame(input int p, input logic bd);
    int len = fd.size();
    for (int i = 0; i < len; i++) begin
      src_t s;
      exp_t e;
      s.data = fd[i];
      s.last = (i == len - 1);
      s.bad  = (i == len - 1) ? bd : 1'($urandom);
      src_q[p].push_back(s);
      if (i < ML) begin
        e.data  = fd[i];
        e.last  = (i == len - 1) || (i == ML - 1);
        e.bad   = (i == len - 1) ? bd : (i == ML - 1);
        e.trunc = (i == ML - 1) && (len > ML);
        exp_q[p].push_back(e);
      end
    end
  endtask

  function automatic bit all_done();
    bit d = (m_state == 0) && (drv_valid == '0);
    for (int p = 0; p < N; p++)
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int c = 0;
    while (!all_done() && c < budget) begin
      @(posedge clk); #2;
      c++;
    end
    chk(nm, all_done(), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  // Source drivers: hold tvalid until handshake, optional random gaps
  initial begin
    drv_valid = '0; s_axis_tdata = '0; s_axis_tlast = '0; s_bad_frame = '0;
    rnd_rdy = 1'b1;
    forever begin
      logic [N-1:0] hs;
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk); #1;
      for (int p = 0; p < N; p++) begin
        if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() == 0) drv_valid[p] = 1'b0;
        else if (!(drv_valid[p] && !hs[p]))
          drv_valid[p] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (src_q[p].size() > 0) begin
          s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
          s_axis_tlast[p]          = src_q[p][0].last;
          s_bad_frame[p]           = src_q[p][0].bad;
        end
      end
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: frame-level arbitration model + scoreboard pops on each output beat
  initial begin
    exp_t e;
    int q;
    bit found;
    m_state = 0; m_owner = 0; m_ptr = N - 1; trunc_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_state = 0;
        m_ptr   = N - 1;
      end else begin
        if (trunc_pulse) trunc_seen++;
        case (m_state)
          0: begin
            chk("idle_grant", grant, 0);
            chk("idle_busy", busy, 0);
            chk("idle_tready", s_axis_tready, 0);
            chk("idle_mvalid", m_axis_tvalid, 0);
            chk("idle_trunc", trunc_pulse, 0);
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
              q = (m_ptr + k) % N;
              if (!found && s_axis_tvalid[q]) begin
                found = 1'b1; m_owner = q; m_ptr = q; m_state = 1;
                glog.push_back(q);
              end
            end
          end
          1: begin
            chk("fwd_grant", grant, 1 << m_owner);
            chk("fwd_busy", busy, 1);
            chk("fwd_tready", s_axis_tready, m_axis_tready ? (1 << m_owner) : 0);
            chk("fwd_mvalid", m_axis_tvalid, s_axis_tvalid[m_owner]);
            if (m_axis_tvalid && m_axis_tready) begin
              chk("exp_avail", exp_q[m_owner].size() > 0, 1);
              if (exp_q[m_owner].size() > 0) begin
                e = exp_q[m_owner].pop_front();
                chk("beat_data", m_axis_tdata, e.data);
                chk("beat_last", m_axis_tlast, e.last);
                chk("beat_bad", m_bad_frame, e.bad);
                chk("beat_trunc", trunc_pulse, e.trunc);
                if (e.last) m_state = e.trunc ? 2 : 0;
              end
            end else begin
              chk("stall_trunc", trunc_pulse, 0);
            end
          end
          default: begin
            chk("drain_grant", grant, 1 << m_owner);
            chk("drain_busy", busy, 1);
            chk("drain_mvalid", m_axis_tvalid, 0);
            chk("drain_tready", s_axis_tready, 1 << m_owner);
            chk("drain_trunc", trunc_pulse, 0);
            if (s_axis_tvalid[m_owner] && s_axis_tlast[m_owner]) m_state = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst = 1'b1; pause = '0; rand_rdy = 1'b0; rdy_force = 1'b1; gaps = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_out", {m_axis_tvalid, m_axis_tlast, m_bad_frame, trunc_pulse}, 0);
    @(posedge clk); #2 rst = 1'b0;

    // 1: exactly-MAX_LEN frame ending naturally on port 0
    glog.delete();
    fd = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h0C, 8'h0F, 8'h0C};
    push_frame(0, 1'b0);
    wait_idle("t1_done", 200);
    chk("t1_nframes", glog.size(), 1);
    if (glog.size() == 1) chk("t1_port", glog[0], 0);

    // 2: all four ports plus an immediate port-0 re-request
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++) begin
      fd.delete();
      for (int j = 0; j < 4; j++) fd.push_back(8'(i * 16 + j));
      push_frame(i, 1'b0);
    end
    fd = '{8'h04, 8'h05, 8'h06, 8'h07};
    push_frame(0, 1'b0);
    wait_idle("t2_done", 400);
    chk("t2_nframes", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("t2_ord0", glog[0], 0);
      chk("t2_ord1", glog[1], 1);
      chk("t2_ord2", glog[2], 2);
      chk("t2_ord3", glog[3], 3);
      chk("t2_ord4", glog[4], 0);
    end

    // 3: bad frame flag on the tlast beat only
    fd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_frame(2, 1'b1);
    wait_idle("t3_done", 200);

    // 4: 12-beat frame truncated at 8 and drained
    trunc_seen = 0;
    fd.delete();
    for (int j = 0; j < 12; j++) fd.push_back(8'(8'h10 + j));
    push_frame(1, 1'b0);
    wait_idle("t4_done", 200);
    chk("t4_trunc_cnt", trunc_seen, 1);

    // 5: sink backpressure for 40 ns, then contiguous transfer
    rdy_force = 1'b0;
    fd.delete();
    for (int j = 0; j < 8; j++) fd.push_back(8'(8'h30 + j));
    push_frame(3, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("t5_tready3", s_axis_tready[3], 0);
    end
    @(posedge clk); #2 rdy_force = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      hit = m_axis_tvalid && m_axis_tready;
    end
    chk("t5_first", hit, 1);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("t5_contig", m_axis_tvalid && m_axis_tready, 1);
    end
    wait_idle("t5_done", 200);

    // 6: reset after beat 3 of a port-0 frame while port 1 requests
    fd.delete();
    for (int j = 0; j < 6; j++) fd.push_back(8'(8'h40 + j));
    push_frame(0, 1'b0);
    repeat (3) begin @(posedge clk); #2; end
    fd = '{8'h50, 8'h51, 8'h52, 8'h53};
    push_frame(1, 1'b0);
    begin
      int c = 0;
      while (src_q[0].size() != 3 && c < 100) begin @(posedge clk); #2; c++; end
      chk("t6_reach_beat3", src_q[0].size(), 3);
    end
    rst = 1'b1; rdy_force = 1'b0; pause[0] = 1'b1;
    glog.delete();
    @(posedge clk); #2 rst = 1'b0; rdy_force = 1'b1;
    @(negedge clk);
    chk("t6_grant0", grant, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_tready0", s_axis_tready, 0);
    @(posedge clk); #2 pause[0] = 1'b0;
    @(negedge clk);
    chk("t6_grant1", grant, 4'b0010);
    wait_idle("t6_done", 300);
    chk("t6_nframes", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t6_ord0", glog[0], 1);
      chk("t6_ord1", glog[1], 0);
    end

    // Random traffic with source gaps and sink backpressure
    do_reset();
    rand_rdy = 1'b1; gaps = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int p = $urandom_range(0, N - 1);
      int len = $urandom_range(1, 12);
      fd.delete();
      for (int j = 0; j < len; j++) fd.push_back(8'($urandom));
      if (src_q[p].size() < 30) push_frame(p, 1'($urandom));
      repeat ($urandom_range(0, 6)) begin @(posedge clk); #2; end
    end
    wait_idle("rand_done", 5000);
    rand_rdy = 1'b0; gaps = 1'b0;

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
